// File: rtl/seq_div_param_if.sv
// Handshake and operand/result bundle for seq_div_param.
interface seq_div_param_if #(
    parameter int unsigned DW = 17,
    parameter int unsigned VW = 12
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;

    // Requester side
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    // Divider side
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/seq_div_param.sv
// seq_div_param: restoring sequential integer divider, one quotient bit per clock,
// fixed latency, optional two's-complement mode (quotient truncates toward zero).
module seq_div_param #(
    parameter int unsigned DW     = 17,
    parameter int unsigned VW     = 12,
    parameter int unsigned SIGNED = 0
) (
    input  logic           clk,
    input  logic           rst,
    seq_div_param_if.slave bus
);
    localparam int unsigned CW  = (DW > 2) ? $clog2(DW) : 1;
    localparam bit          SGN = (SIGNED != 0);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FIN} state_e;

    state_e        state_q;
    logic          busy_q;
    logic          done_q;
    logic          dz_q;
    logic [DW-1:0] quo_q;
    logic [VW-1:0] rmd_q;
    logic [DW-1:0] ddo_q;    // dividend, shifted out MSB-first while quotient bits enter at the LSB
    logic [VW-1:0] dsor_q;
    logic [VW-1:0] rem_q;    // partial remainder, always < divisor between steps
    logic [CW-1:0] cnt_q;
    logic          qneg_q;
    logic          rneg_q;
    logic          zdiv_q;

    logic [VW:0]   shift_d;
    logic [VW-1:0] diff_d;
    logic          ge_d;
    logic [VW-1:0] rem_d;
    logic [DW-1:0] ddo_d;
    logic [DW-1:0] ddo_mag_d;
    logic [VW-1:0] dsor_mag_d;
    logic [DW-1:0] quo_fin_d;
    logic [VW-1:0] rmd_fin_d;

    // One restoring step, operand magnitudes and final sign correction
    always_comb begin
        shift_d    = {rem_q, ddo_q[DW-1]};
        diff_d     = VW'(shift_d - {1'b0, dsor_q});
        ge_d       = (shift_d >= {1'b0, dsor_q});
        rem_d      = ge_d ? diff_d : shift_d[VW-1:0];
        ddo_d      = {ddo_q[DW-2:0], ge_d};
        ddo_mag_d  = (SGN && ddo_q[DW-1])  ? (~ddo_q + DW'(1))  : ddo_q;
        dsor_mag_d = (SGN && dsor_q[VW-1]) ? (~dsor_q + VW'(1)) : dsor_q;
        quo_fin_d  = qneg_q ? (~ddo_q + DW'(1)) : ddo_q;
        rmd_fin_d  = rneg_q ? (~rem_q + VW'(1)) : rem_q;
    end

    // Control FSM with datapath registers; every output is registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            ddo_q   <= '0;
            dsor_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zdiv_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    // The done cycle is not yet a true idle cycle, so start is ignored there
                    if (bus.start && !done_q) begin
                        ddo_q   <= bus.dividend;
                        dsor_q  <= bus.divisor;
                        zdiv_q  <= (bus.divisor == '0);
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    qneg_q  <= SGN && (ddo_q[DW-1] ^ dsor_q[VW-1]);
                    rneg_q  <= SGN && ddo_q[DW-1];
                    ddo_q   <= ddo_mag_d;
                    dsor_q  <= dsor_mag_d;
                    rem_q   <= '0;
                    cnt_q   <= CW'(DW - 1);
                    // Zero divisor skips the iterations, giving a two-edge latency
                    state_q <= zdiv_q ? S_FIN : S_RUN;
                end
                S_RUN: begin
                    rem_q <= rem_d;
                    ddo_q <= ddo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (zdiv_q) begin
                        quo_q <= '1;
                        rmd_q <= '0;
                        dz_q  <= 1'b1;
                    end else begin
                        quo_q <= quo_fin_d;
                        rmd_q <= rmd_fin_d;
                        dz_q  <= 1'b0;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rmd_q;
    assign bus.div_zero  = dz_q;
endmodule
